sha256_msg_schedule: RTL

- Generates the SHA-256 message schedule W0..W63 for one 512-bit block and streams one word per handshake to the compression round logic, which consumes the words alongside the Σ0/Σ1 round functions.
- Accepts the 16 block words serially through an input handshake, then expands and emits all 64 schedule words in order through an output handshake with backpressure.

---
 rtl/sha256_msg_schedule.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule generator.
//
// Accepts the 16 words of one 512-bit block serially (M0 first), then streams
// the 64 schedule words W0..W63 to the compression rounds, one word per
// handshake. The expansion uses a 16-word sliding window: win[0] is always
// the current Wt. Each accepted output word shifts the window down by one and
// appends the next recurrence term at win[15].
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset (discards any partial block)
//   din        message word input
//   din_valid  din is valid
//   din_ready  block is in LOAD and can take a word
//   w_out      current schedule word Wt
//   w_idx      index t of w_out
//   w_valid    w_out / w_idx are valid (STREAM)
//   w_ready    consumer accepts the word
//   w_last     high with w_valid when t = NUM_ROUNDS-1
//   busy       high while streaming
module sha256_msg_schedule #(
  // Only 32 is legal: the sigma rotate/shift amounts are fixed SHA-256 constants.
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [DATA_WIDTH-1:0] w_out,
  output logic [5:0]            w_idx,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic                  w_last,
  output logic                  busy
);

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [DATA_WIDTH-1:0] win [16];
  logic [3:0]            load_cnt;
  logic [5:0]            stream_cnt;
  logic                  load_hs;
  logic                  w_hs;
  logic [DATA_WIDTH-1:0] w_new;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign load_hs = (state == LOAD) && din_valid;
  assign w_hs    = w_valid && w_ready;

  // Viewed from the shifted window, win[14], win[9], win[1], win[0] are
  // W(t-2), W(t-7), W(t-15), W(t-16) of the word being appended. The sum
  // wraps at 32 bits; the carry is dropped.
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    w_valid   = 1'b0;
    busy      = 1'b0;
    w_last    = 1'b0;
    case (state)
      LOAD: begin
        din_ready = 1'b1;
        if (din_valid && (load_cnt == 4'd15)) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        w_valid = 1'b1;
        busy    = 1'b1;
        w_last  = (stream_cnt == 6'(NUM_ROUNDS - 1));
        if (w_ready && w_last) begin
          state_nxt = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign w_out = win[0];
  assign w_idx = stream_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt   <= 4'd0;
      stream_cnt <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        win[i] <= '0;
      end
    end else if (load_hs) begin
      // Counter wraps 15 -> 0 on the 16th word, ready for the next block.
      win[load_cnt] <= din;
      load_cnt      <= load_cnt + 4'd1;
    end else if (w_hs) begin
      for (int i = 0; i < 15; i++) begin
        win[i] <= win[i + 1];
      end
      win[15] <= w_new;
      if (w_last) begin
        stream_cnt <= 6'd0;
      end else begin
        stream_cnt <= stream_cnt + 6'd1;
      end
    end
  end

endmodule
